// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_pkg
//  Purpose  : Shared opcode map, stage field widths, fncode decode and ALU
//             evaluation for the alu_pipe_arbiter pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pipe_pkg;

  localparam int OPW          = 3;
  localparam int DW           = 4;
  localparam int FNW          = 8;
  localparam int S1_PAYLOAD_W = OPW + 2 * DW;

  localparam logic [OPW-1:0] OP_ADD  = 3'd0;
  localparam logic [OPW-1:0] OP_SUB  = 3'd1;
  localparam logic [OPW-1:0] OP_XOR  = 3'd2;
  localparam logic [OPW-1:0] OP_OR   = 3'd3;
  localparam logic [OPW-1:0] OP_AND  = 3'd4;
  localparam logic [OPW-1:0] OP_NOR  = 3'd5;
  localparam logic [OPW-1:0] OP_NAND = 3'd6;
  localparam logic [OPW-1:0] OP_XNOR = 3'd7;

  // S1 payload: opcode + both operands (11 bits)
  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } s1_payload_t;

  // True when exactly one fncode bit is set
  function automatic logic fncode_is_onehot(input logic [FNW-1:0] fn);
    return (fn != '0) && ((fn & (fn - FNW'(1))) == '0);
  endfunction

  // One-hot fncode to 3-bit opcode; anything not one-hot falls back to ADD
  function automatic logic [OPW-1:0] fncode_to_opcode(input logic [FNW-1:0] fn);
    logic [OPW-1:0] op;
    op = OP_ADD;
    for (int k = 0; k < FNW; k++) begin
      if (fn == (FNW'(1) << k)) op = OPW'(k);
    end
    return op;
  endfunction

  // 4-bit ALU, carries and borrows discarded
  function automatic logic [DW-1:0] alu_eval(input logic [OPW-1:0] op,
                                             input logic [DW-1:0]  a,
                                             input logic [DW-1:0]  b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_NOR:  return ~(a | b);
      OP_NAND: return ~(a & b);
      OP_XNOR: return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipe_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_rr_arb
//  Purpose  : NREQ-way round-robin arbiter. Searches req_i starting at ptr_i
//             and returns a one-hot grant. Pointer update lives in the parent.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_pipe_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o
);

  logic found;
  int   idx;

  // First asserted request at or after the pointer, wrapping around
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr_i) + off) % NREQ;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_arbiter
//  Purpose  : Round-robin shares one 3-stage encode -> ALU -> parity pipeline
//             between NREQ requesters; results tagged with requester ID; the
//             whole pipeline freezes on output backpressure.
//  Option   : ALU_PIPE_ILLEGAL_CHK_EN - flag non-one-hot fncodes via res_err_o
//             (result forced to zero). Undefined: they execute as ADD.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_pipe_arbiter
  import alu_pipe_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [FNW*NREQ-1:0] req_fncode_i,
  input  logic [DW*NREQ-1:0]  req_srcA_i,
  input  logic [DW*NREQ-1:0]  req_srcB_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [IDW-1:0]      res_id_o,
  output logic [DW-1:0]       res_alu_o,
  output logic                res_parity_o,
  output logic                res_err_o,
  output logic                busy_o
);

  logic            stall, adv, accept;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  ptr_q, ptr_d, acc_id;
  logic [FNW-1:0]  sel_fn;
  s1_payload_t     s1_pay_d, s1_pay_q;
  logic            s1_valid_q, s2_valid_q, res_valid_q;
  logic [IDW-1:0]  s1_id_q, s2_id_q, res_id_q;
  logic [DW-1:0]   ex_alu, s2_alu_q, res_alu_q;
  logic            res_parity_q;

  // Any valid output not taken by the consumer freezes every stage
  assign stall = res_valid_q & ~res_ready_i;
  assign adv   = ~stall;

  alu_pipe_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // Ready is suppressed while stalled and while reset is held
  assign req_ready_o = grant & {NREQ{adv & rst_n}};
  assign accept      = |(req_valid_i & req_ready_o);

  // Index of the granted requester
  always_comb begin
    acc_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) acc_id = IDW'(i);
    end
  end

  assign sel_fn      = req_fncode_i[int'(acc_id)*FNW +: FNW];
  assign s1_pay_d.op = fncode_to_opcode(sel_fn);
  assign s1_pay_d.a  = req_srcA_i[int'(acc_id)*DW +: DW];
  assign s1_pay_d.b  = req_srcB_i[int'(acc_id)*DW +: DW];

  // Next pointer: one past the requester just accepted, else hold
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (int'(acc_id) == NREQ - 1) ? '0 : acc_id + IDW'(1);
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

`ifdef ALU_PIPE_ILLEGAL_CHK_EN
  logic s1_err_q, s2_err_q, res_err_q;

  // Illegal-fncode flag travels alongside the payload; result forced to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err_q  <= 1'b0;
      s2_err_q  <= 1'b0;
      res_err_q <= 1'b0;
    end else if (adv) begin
      if (accept) s1_err_q <= ~fncode_is_onehot(sel_fn);
      s2_err_q  <= s1_err_q;
      res_err_q <= s2_err_q;
    end
  end

  assign ex_alu    = s1_err_q ? '0 : alu_eval(s1_pay_q.op, s1_pay_q.a, s1_pay_q.b);
  assign res_err_o = res_err_q;
`else
  assign ex_alu    = alu_eval(s1_pay_q.op, s1_pay_q.a, s1_pay_q.b);
  assign res_err_o = 1'b0;
`endif

  // S1: capture the accepted request, or insert a bubble when advancing idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_pay_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_id_q  <= acc_id;
        s1_pay_q <= s1_pay_d;
      end
    end
  end

  // S2: evaluate the ALU on the S1 payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_alu_q   <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_id_q    <= s1_id_q;
      s2_alu_q   <= ex_alu;
    end
  end

  // S3: registered result outputs with parity of the ALU value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_alu_q    <= '0;
      res_parity_q <= 1'b0;
    end else if (adv) begin
      res_valid_q  <= s2_valid_q;
      res_id_q     <= s2_id_q;
      res_alu_q    <= s2_alu_q;
      res_parity_q <= ^s2_alu_q;
    end
  end

  assign res_valid_o  = res_valid_q;
  assign res_id_o     = res_id_q;
  assign res_alu_o    = res_alu_q;
  assign res_parity_o = res_parity_q;
  assign busy_o       = s1_valid_q | s2_valid_q | res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe_arbiter
//  Purpose  : Self-checking bench for alu_pipe_arbiter (NREQ = 2). A monitor
//             keeps a round-robin/result model; scenario tasks add their own
//             targeted checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [3:0]     alu;
    logic           par;
    logic           err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [8*NREQ-1:0] req_fncode_i;
  logic [4*NREQ-1:0] req_srcA_i;
  logic [4*NREQ-1:0] req_srcB_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [IDW-1:0]    res_id_o;
  logic [3:0]        res_alu_o;
  logic              res_parity_o;
  logic              res_err_o;
  logic              busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  // model state
  exp_t            exp_q[$];
  int              m_ptr = 0;
  logic [NREQ-1:0] acc_seen = '0;
  logic [NREQ-1:0] m_rdy;
  logic            m_found, m_stall, m_prev_stall = 1'b0;
  logic [7:0]      m_snap;
  exp_t            m_e;

  alu_pipe_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_fncode_i (req_fncode_i),
    .req_srcA_i   (req_srcA_i),
    .req_srcB_i   (req_srcB_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_id_o     (res_id_o),
    .res_alu_o    (res_alu_o),
    .res_parity_o (res_parity_o),
    .res_err_o    (res_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Expected result of one operation, straight from the opcode table
  function automatic exp_t model(input int id, input logic [7:0] fn,
                                 input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int   r;
    e.id  = IDW'(id);
    e.err = 1'b0;
    r     = 0;
    if ($countones(fn) != 1) begin
`ifdef ALU_PIPE_ILLEGAL_CHK_EN
      e.err = 1'b1;
      r     = 0;
`else
      r = (int'(a) + int'(b)) % 16;
`endif
    end else begin
      case (fn)
        8'h01:   r = (int'(a) + int'(b)) % 16;
        8'h02:   r = (int'(a) - int'(b) + 16) % 16;
        8'h04:   r = int'(a ^ b);
        8'h08:   r = int'(a | b);
        8'h10:   r = int'(a & b);
        8'h20:   r = 15 - int'(a | b);
        8'h40:   r = 15 - int'(a & b);
        default: r = 15 - int'(a ^ b);
      endcase
    end
    e.alu = 4'(r);
    e.par = ($countones(e.alu) % 2) == 1;
    return e;
  endfunction

  // Monitor: checks ready against a round-robin model, results against the queue
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ptr        = 0;
      acc_seen     = '0;
      m_prev_stall = 1'b0;
    end else begin
      m_stall = res_valid_o && !res_ready_i;
      if (m_prev_stall) begin
        n_tests++;
        if ({res_valid_o, res_id_o, res_alu_o, res_parity_o, res_err_o} !== m_snap) begin
          n_fail++;
          $display("FAIL stall_hold: got %h required %h", {res_valid_o, res_id_o, res_alu_o, res_parity_o, res_err_o}, m_snap);
        end
      end
      m_snap       = {res_valid_o, res_id_o, res_alu_o, res_parity_o, res_err_o};
      m_prev_stall = m_stall;

      m_rdy   = '0;
      m_found = 1'b0;
      if (!m_stall) begin
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (m_ptr + k) % NREQ;
          if (!m_found && req_valid_i[j]) begin
            m_rdy[j] = 1'b1;
            m_found  = 1'b1;
          end
        end
      end
      n_tests++;
      if (req_ready_o !== m_rdy) begin
        n_fail++;
        $display("FAIL req_ready @%0t: got %b required %b", $time, req_ready_o, m_rdy);
      end

      if (res_valid_o === 1'b1 && res_ready_i) begin
        n_done++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result @%0t: got id %0d alu %h, required no result", $time, res_id_o, res_alu_o);
        end else begin
          m_e = exp_q.pop_front();
          if ({res_id_o, res_alu_o, res_parity_o, res_err_o} !== m_e) begin
            n_fail++;
            $display("FAIL result @%0t: got id %0d alu %h par %b err %b, required id %0d alu %h par %b err %b",
                     $time, res_id_o, res_alu_o, res_parity_o, res_err_o, m_e.id, m_e.alu, m_e.par, m_e.err);
          end
        end
      end

      acc_seen = m_rdy & req_valid_i;
      for (int j = 0; j < NREQ; j++) begin
        if (acc_seen[j]) begin
          exp_q.push_back(model(j, req_fncode_i[j*8 +: 8], req_srcA_i[j*4 +: 4], req_srcB_i[j*4 +: 4]));
          m_ptr = (j + 1) % NREQ;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [7:0] fn,
                         input logic [3:0] a, input logic [3:0] b);
    req_valid_i[i]        = v;
    req_fncode_i[i*8 +: 8] = fn;
    req_srcA_i[i*4 +: 4]  = a;
    req_srcB_i[i*4 +: 4]  = b;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b1;
    req_valid_i  = '0;
    req_fncode_i = '0;
    req_srcA_i   = '0;
    req_srcB_i   = '0;
    res_ready_i  = 1'b1;
    #2 rst_n = 1'b0;
    req_valid_i = 2'b11;
    #1;
    n_tests++;
    if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b required 00", req_ready_o); end
    n_tests++;
    if ({res_valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL reset_valid_busy: got %b required 00", {res_valid_o, busy_o}); end
    n_tests++;
    if ({res_id_o, res_alu_o, res_parity_o, res_err_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_res: got %h required 0", {res_id_o, res_alu_o, res_parity_o, res_err_o});
    end
    req_valid_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [2:0] seen;
    set_req(0, 1'b1, 8'h01, 4'b0001, 4'b0001);
    cyc();
    req_valid_i = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen[c] = res_valid_o;
    end
    n_tests++;
    if (seen !== 3'b100) begin n_fail++; $display("FAIL single_latency: got valid pattern %b required 100", seen); end
    n_tests++;
    if ({res_id_o, res_alu_o, res_parity_o, res_err_o} !== {1'b0, 4'b0010, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_result: got id %0d alu %b par %b err %b required id 0 alu 0010 par 1 err 0",
               res_id_o, res_alu_o, res_parity_o, res_err_o);
    end
    cyc();
    repeat (2) cyc();
  endtask

  task automatic test_full_rate();
    logic [NREQ-1:0] prev;
    set_req(0, 1'b1, 8'h02, 4'b0101, 4'b1010);
    set_req(1, 1'b1, 8'h04, 4'b0101, 4'b1010);
    prev = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_tests++;
        if (!$onehot(req_ready_o) || req_ready_o !== ~prev) begin
          n_fail++;
          $display("FAIL full_rate_toggle: got %b required %b", req_ready_o, ~prev);
        end
      end
      prev = req_ready_o;
      cyc();
    end
    req_valid_i = '0;
    repeat (4) cyc();
  endtask

  task automatic test_backpressure();
    logic [7:0] snap;
    int         d0;
    set_req(0, 1'b1, 8'h01, 4'd3, 4'd4);
    cyc();
    req_valid_i[0] = 1'b0;
    set_req(1, 1'b1, 8'h08, 4'd9, 4'd2);
    cyc();
    req_valid_i[1] = 1'b0;
    set_req(0, 1'b1, 8'h80, 4'd6, 4'd5);
    cyc();
    set_req(0, 1'b1, 8'h10, 4'hF, 4'h6);
    res_ready_i = 1'b0;
    snap = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        snap = {res_valid_o, res_id_o, res_alu_o, res_parity_o, res_err_o};
        n_tests++;
        if ({res_valid_o, busy_o} !== 2'b11) begin n_fail++; $display("FAIL bp_full: got valid/busy %b required 11", {res_valid_o, busy_o}); end
      end
      n_tests++;
      if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL bp_ready: got %b required 00", req_ready_o); end
      n_tests++;
      if ({res_valid_o, res_id_o, res_alu_o, res_parity_o, res_err_o} !== snap) begin
        n_fail++;
        $display("FAIL bp_hold: got %h required %h", {res_valid_o, res_id_o, res_alu_o, res_parity_o, res_err_o}, snap);
      end
      cyc();
    end
    res_ready_i = 1'b1;
    d0 = n_done;
    cyc();
    req_valid_i = '0;
    repeat (5) cyc();
    n_tests++;
    if (n_done - d0 != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d results (%0d pending) required 4 (0 pending)", n_done - d0, exp_q.size());
    end
  endtask

  task automatic test_corners();
    logic [7:0] fns[6] = '{8'h01, 8'h20, 8'h40, 8'h03, 8'h00, 8'h08};
    logic [3:0] as[6]  = '{4'hF, 4'h5, 4'h0, 4'h3, 4'h2, 4'h9};
    logic [3:0] bs[6]  = '{4'h1, 4'hA, 4'h0, 4'h4, 4'h2, 4'h6};
`ifdef ALU_PIPE_ILLEGAL_CHK_EN
    logic [5:0] want[6] = '{6'b0000_0_0, 6'b0000_0_0, 6'b1111_0_0, 6'b0000_0_1, 6'b0000_0_1, 6'b1111_0_0};
`else
    logic [5:0] want[6] = '{6'b0000_0_0, 6'b0000_0_0, 6'b1111_0_0, 6'b0111_1_0, 6'b0100_1_0, 6'b1111_0_0};
`endif
    for (int t = 0; t < 6; t++) begin
      set_req(1, 1'b1, fns[t], as[t], bs[t]);
      cyc();
      req_valid_i[1] = 1'b0;
      repeat (2) cyc();
      n_tests++;
      if ({res_valid_o, res_id_o, res_alu_o, res_parity_o, res_err_o} !== {2'b11, want[t]}) begin
        n_fail++;
        $display("FAIL corner_%0d fn %h: got v %b id %0d alu %b par %b err %b, required v 1 id 1 alu %b par %b err %b",
                 t, fns[t], res_valid_o, res_id_o, res_alu_o, res_parity_o, res_err_o, want[t][5:2], want[t][1], want[t][0]);
      end
    end
    repeat (2) cyc();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc_seen[i] || !req_valid_i[i]) begin
          if ($urandom_range(0, 3) != 0)
            set_req(i, 1'b1,
                    ($urandom_range(0, 7) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7)),
                    4'($urandom), 4'($urandom));
          else
            req_valid_i[i] = 1'b0;
        end
      end
      res_ready_i = ($urandom_range(0, 3) != 0);
      cyc();
    end
    req_valid_i = '0;
    res_ready_i = 1'b1;
    repeat (6) cyc();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 8'h01, 4'd7, 4'd7);
    set_req(1, 1'b1, 8'h02, 4'd1, 4'd9);
    res_ready_i = 1'b1;
    repeat (4) cyc();
    n_tests++;
    if ({res_valid_o, busy_o} !== 2'b11) begin n_fail++; $display("FAIL mid_full: got valid/busy %b required 11", {res_valid_o, busy_o}); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({res_valid_o, busy_o, req_ready_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_drop: got valid/busy/ready %b required 0000", {res_valid_o, busy_o, req_ready_o});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant: got %b required 01", req_ready_o); end
    cyc();
    req_valid_i = '0;
    repeat (5) cyc();
    n_tests++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_drain: got %0d pending busy %b required 0 pending busy 0", exp_q.size(), busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_rate();
    test_backpressure();
    test_corners();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe_arbiter.md
# alu_pipe_arbiter

Shares one three-stage encode → ALU → parity pipeline between `NREQ` requesters. Each requester submits an operation through a valid/ready handshake. A round-robin arbiter picks one request per cycle and feeds it into registered pipeline stages. Each result comes back tagged with the requester ID, and the whole pipeline stalls on output backpressure.

## Interface
- `NREQ`, 2, number of requesters; legal range 2–4.
- `IDW`, `$clog2(NREQ)`, width of the requester ID tag.
- `clk`  in  1  single clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_fncode`  in  8·NREQ  one-hot function code per requester (slot i = bits 8i+7:8i).
- `req_srcA`, `req_srcB`  in  4·NREQ  operands per requester.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts result.
- `res_id`  out  IDW  requester that issued the result.
- `res_alu`  out  4  ALU result.
- `res_parity`  out  1  XOR of `res_alu` bits.
- `res_err`  out  1  illegal fncode flag (see Configuration).
- `busy`  out  1  any pipeline stage valid.

## Operation
- Opcode map (fncode bit → op): bit0 ADD, bit1 SUB, bit2 XOR, bit3 OR, bit4 AND, bit5 NOR, bit6 NAND, bit7 XNOR. Encoded 3'b000..3'b111 in that order.
- Arithmetic is 4-bit modulo 16. Carries and borrows are discarded: SUB 0001−0010 = 1111.
- `stall = res_valid & ~res_ready`. `adv = ~stall`. When `adv` is low, every stage register holds its value.
- Arbitration:
  - `grant` is the round-robin choice among `req_valid` bits, starting the search at pointer `ptr`.
  - `req_ready = grant & {NREQ{adv}}`.
  - A request is accepted when `req_valid[i] & req_ready[i]` at a rising edge.
  - After an accept from i, `ptr` becomes (i+1) mod NREQ. Without an accept, `ptr` holds.
- Stage S1 (IF_EX) loads on accept: valid, id, opcode(3), srcA(4), srcB(4), err. If `adv` is set and there is no accept, S1.valid is cleared.
- Stage S2 (EX_PAR) loads from S1 when `adv`: valid, id, alu(4), err.
- Stage S3 (output) loads from S2 when `adv`: drives `res_*`, with parity computed from S2.alu.
- `busy = S1.valid | S2.valid | S3.valid`.
- Requests from a single requester complete in order. Results from different requesters come out in accept order.
- The arbiter contains no state machine beyond `ptr` and the stage valid bits. The valid bits form a bubble-capable shift pipeline.

## Timing
- Request accepted at edge E → S1 at E, S2 at E+1, `res_valid` high after E+2. Without stall, latency is 3 cycles and throughput is 1 op/cycle.
- Full rate with all requesters valid: grants rotate 0,1,…,NREQ−1,0.
- While stalled, `req_ready` is all zero. A requester must keep `req_valid` and its data stable until accepted.
- A stall with bubbles in S1/S2 does not compress them. The pipeline freezes as a whole.
- `req_ready` depends combinationally on `req_valid` and `res_ready`. `res_*` are registered outputs.
- Reset (asserted at any time, including mid-operation) has these effects immediately:
  - all stage valids 0, `ptr` = 0;
  - `res_valid`, `res_alu`, `res_parity`, `res_err`, `res_id`, `busy` = 0;
  - `req_ready` = 0 while `rst_n` is low.
- In-flight operations are discarded on reset. The first grant after reset goes to the lowest-index valid requester.

## Configuration
- `ALU_PIPE_ILLEGAL_CHK_EN` defined:
  - A non-one-hot fncode (zero or more than one bit set) is still accepted.
  - That result carries `res_err` = 1, `res_alu` = 0, `res_parity` = 0.
- `ALU_PIPE_ILLEGAL_CHK_EN` undefined:
  - A non-one-hot fncode encodes as ADD.
  - `res_err` is tied to 0 and no check logic is built.

## Structure
- Shared package `alu_pipe_pkg` holds:
  - opcode constants ADD..XNOR;
  - the `fncode_to_opcode` function;
  - the ALU evaluation function;
  - stage field widths (S1 payload 11 bits: 3+4+4).
- Sub-module `alu_pipe_rr_arb`: NREQ-way round-robin arbiter with inputs `req`, `ptr` and output one-hot `grant`. The pointer update stays in the parent.

## Test plan
- Single op: requester 0, fncode 0x01, srcA 0001, srcB 0001 → after 3 cycles `res_valid`, id 0, alu 0010, parity 1.
- Full rate, both requesters valid continuously: req0 SUB 0101/1010, req1 XOR 0101/1010.
  - Results alternate id 0 (alu 1011, parity 1) and id 1 (alu 1111, parity 0), one per cycle.
  - `req_ready` toggles between the two requesters every cycle.
- Backpressure: hold `res_ready` = 0 for 4 cycles with 3 ops in flight.
  - `res_*` stay stable and `req_ready` stays 0 throughout.
  - After release, all 3 results drain in order with none lost or duplicated.
- Wrap and overflow: ADD 1111+0001 → 0000, parity 0. NOR 0101/1010 → 0000. NAND 0000/0000 → 1111, parity 0.
- Illegal fncode 0x03:
  - with the macro: `res_err` 1, alu 0000;
  - without it: ADD result and `res_err` 0.
- Reset mid-stream: assert `rst_n` low while S1–S3 are valid.
  - `res_valid` and `busy` drop immediately.
  - After release, the first grant goes to requester 0 and no stale result appears.
